dvi_rx_tmds_word_align: RTL and testbench



---
 rtl/dvi_rx_tmds_word_align_if.sv | 25 ++
 rtl/dvi_rx_tmds_word_align.sv | 168 ++++++++++++++++
 tb/tb_dvi_rx_tmds_word_align.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dvi_rx_tmds_word_align_if.sv
// Lane interface between the 1:10 deserializer and the TMDS decoder:
// raw words in, aligned symbols with lock status out.
interface dvi_rx_tmds_word_align_if;
    localparam int unsigned SYM_W = 10;
    localparam int unsigned OFF_W = 4;
    localparam int unsigned CNT_W = 8;

    logic [SYM_W-1:0] raw_data;
    logic [SYM_W-1:0] data_out;
    logic             data_valid;
    logic             is_ctrl;
    logic             locked;
    logic [OFF_W-1:0] bit_offset;
    logic [CNT_W-1:0] realign_count;

    modport master (
        output raw_data,
        input  data_out, data_valid, is_ctrl, locked, bit_offset, realign_count
    );

    modport slave (
        input  raw_data,
        output data_out, data_valid, is_ctrl, locked, bit_offset, realign_count
    );
endinterface

// File: rtl/dvi_rx_tmds_word_align.sv
// TMDS receive word aligner: finds the symbol boundary from blanking control
// tokens, bit-reverses into first-transmitted-in-LSB order and tracks lock.
module dvi_rx_tmds_word_align #(
    parameter int unsigned LOCK_TOKENS  = 8,
    parameter int unsigned LOSS_TIMEOUT = 4096
) (
    input  logic                           pixel_clock,
    input  logic                           reset_n,
    dvi_rx_tmds_word_align_if.slave        rx
);
    localparam int unsigned SYM_W   = 10;
    localparam int unsigned WIN_W   = 2 * SYM_W;
    localparam int unsigned NUM_OFF = 10;
    localparam int unsigned OFF_W   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TMR_W   = $clog2(LOSS_TIMEOUT);

    localparam logic [SYM_W-1:0] TOK_0 = 10'h354;
    localparam logic [SYM_W-1:0] TOK_1 = 10'h0AB;
    localparam logic [SYM_W-1:0] TOK_2 = 10'h154;
    localparam logic [SYM_W-1:0] TOK_3 = 10'h2AB;

    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(LOSS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LOCK_TOKENS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic is_token(input logic [SYM_W-1:0] s);
        return (s == TOK_0) || (s == TOK_1) || (s == TOK_2) || (s == TOK_3);
    endfunction

    state_t state_q, state_d;

    logic [SYM_W-1:0] prev_q;
    logic [OFF_W-1:0] off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] realign_q, realign_d;

    logic [SYM_W-1:0] data_q;
    logic             valid_q;
    logic             ctrl_q;
    logic             locked_q;

    logic [WIN_W-1:0]                  window;
    logic [NUM_OFF-1:0][SYM_W-1:0]     sym;
    logic [NUM_OFF-1:0]                match;
    logic [OFF_W-1:0]                  first_off;
    logic                              any_match;
    logic [SYM_W-1:0]                  sym_sel;
    logic                              sel_tok;

    assign window = {prev_q, rx.raw_data};

    // Candidate k starts k bits into the older word; first-received bit lands in bit 0.
    for (genvar k = 0; k < NUM_OFF; k++) begin : g_off
        for (genvar i = 0; i < SYM_W; i++) begin : g_bit
            assign sym[k][i] = window[WIN_W-1-k-i];
        end
        assign match[k] = is_token(sym[k]);
    end

    assign any_match = |match;
    assign sym_sel   = sym[off_q];
    assign sel_tok   = is_token(sym_sel);

    // Lowest matching offset wins when several candidates alias to a token.
    always_comb begin
        first_off = 4'd0;
        casez (match)
            10'b?????????1: first_off = 4'd0;
            10'b????????10: first_off = 4'd1;
            10'b???????100: first_off = 4'd2;
            10'b??????1000: first_off = 4'd3;
            10'b?????10000: first_off = 4'd4;
            10'b????100000: first_off = 4'd5;
            10'b???1000000: first_off = 4'd6;
            10'b??10000000: first_off = 4'd7;
            10'b?100000000: first_off = 4'd8;
            10'b1000000000: first_off = 4'd9;
            default:        first_off = 4'd0;
        endcase
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_SEARCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        realign_d = realign_q;
        case (state_q)
            ST_SEARCH: begin
                if (any_match) begin
                    off_d   = first_off;
                    cnt_d   = 8'd1;
                    state_d = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (sel_tok) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q >= CNT_LAST) begin
                        state_d = ST_LOCKED;
                        tmr_d   = '0;
                    end
                end else begin
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end
            end
            ST_LOCKED: begin
                // Only a long absence of tokens drops lock; pixel data alone never does.
                if (sel_tok) begin
                    tmr_d = '0;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    if (realign_q != CNT_SAT) realign_d = realign_q + 8'd1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            off_q     <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            realign_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ctrl_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            prev_q    <= rx.raw_data;
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            realign_q <= realign_d;
            data_q    <= sym_sel;
            valid_q   <= (state_q != ST_SEARCH);
            ctrl_q    <= sel_tok;
            locked_q  <= (state_d == ST_LOCKED);
        end
    end

    assign rx.data_out      = data_q;
    assign rx.data_valid    = valid_q;
    assign rx.is_ctrl       = ctrl_q;
    assign rx.locked        = locked_q;
    assign rx.bit_offset    = off_q;
    assign rx.realign_count = realign_q;
endmodule

// File: tb/tb_dvi_rx_tmds_word_align.sv
// Bench for the TMDS word aligner: serializes symbols into a bit stream with
// a chosen slip, and scores every output cycle against a bit-stream model.
module tb_dvi_rx_tmds_word_align;
    localparam int LOCK_TOKENS  = 8;
    localparam int LOSS_TIMEOUT = 16;

    localparam logic [9:0] TOK_354 = 10'h354;
    localparam logic [9:0] TOK_0AB = 10'h0AB;
    localparam logic [9:0] TOK_154 = 10'h154;
    localparam logic [9:0] TOK_2AB = 10'h2AB;
    localparam logic [9:0] PIX_1F0 = 10'h1F0;

    typedef struct packed {
        logic [9:0] d;
        logic       v;
        logic       c;
        logic       l;
        logic [3:0] off;
        logic [7:0] rc;
    } exp_t;

    typedef enum {M_SEARCH, M_VERIFY, M_LOCKED} mstate_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dvi_rx_tmds_word_align_if rx_if();

    dvi_rx_tmds_word_align #(
        .LOCK_TOKENS (LOCK_TOKENS),
        .LOSS_TIMEOUT(LOSS_TIMEOUT)
    ) dut (
        .pixel_clock(clk),
        .reset_n    (rst_n),
        .rx         (rx_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sb[$];
    bit   tx_bits[$];
    bit   hist[$];          // last 20 received bits, oldest first
    mstate_t m_st;
    int   m_off, m_run, m_idle, m_rc;
    logic [9:0] toks [4] = '{TOK_354, TOK_0AB, TOK_154, TOK_2AB};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_tok(input logic [9:0] s);
        return (s == TOK_354) || (s == TOK_0AB) || (s == TOK_154) || (s == TOK_2AB);
    endfunction

    // Symbol whose first transmitted bit sits k bits into the older word.
    function automatic logic [9:0] cand(input int k);
        logic [9:0] s;
        for (int i = 0; i < 10; i++) s[i] = hist[k+i];
        return s;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 10; i++) hist.push_back(1'b0);
        m_st = M_SEARCH; m_off = 0; m_run = 0; m_idle = 0; m_rc = 0;
    endtask

    task automatic model_step(input logic [9:0] w);
        exp_t e;
        logic [9:0] s;
        bit tok;
        int first;
        for (int j = 0; j < 10; j++) hist.push_back(w[9-j]);
        while (hist.size() > 20) void'(hist.pop_front());
        s   = cand(m_off);
        tok = is_tok(s);
        e.d = s;
        e.c = tok;
        e.v = (m_st != M_SEARCH);
        case (m_st)
            M_SEARCH: begin
                first = -1;
                for (int k = 9; k >= 0; k--) if (is_tok(cand(k))) first = k;
                if (first >= 0) begin m_off = first; m_run = 1; m_st = M_VERIFY; end
            end
            M_VERIFY: begin
                if (tok) begin
                    m_run++;
                    if (m_run >= LOCK_TOKENS) begin m_st = M_LOCKED; m_idle = 0; end
                end else begin
                    m_st = M_SEARCH; m_run = 0;
                end
            end
            default: begin
                if (tok) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle >= LOSS_TIMEOUT) begin
                        m_st = M_SEARCH; m_run = 0;
                        if (m_rc < 255) m_rc++;
                    end
                end
            end
        endcase
        e.l   = (m_st == M_LOCKED);
        e.off = 4'(m_off);
        e.rc  = 8'(m_rc);
        sb.push_back(e);
    endtask

    task automatic step(input logic [9:0] w);
        rx_if.raw_data = w;
        @(posedge clk);
        model_step(w);
        #1;
    endtask

    // Serialize one symbol LSB-first and hand every complete word to the DUT.
    task automatic send(input logic [9:0] s);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) tx_bits.push_back(s[i]);
        while (tx_bits.size() >= 10) begin
            for (int j = 0; j < 10; j++) w[9-j] = tx_bits.pop_front();
            step(w);
        end
    endtask

    task automatic chk_zero(input string name);
        check(name, 32'({rx_if.data_out, rx_if.data_valid, rx_if.is_ctrl, rx_if.locked,
                         rx_if.bit_offset, rx_if.realign_count}), 32'd0);
    endtask

    task automatic do_reset(input int slip, input bit rnd);
        #6;
        rst_n = 1'b0;
        #1;
        chk_zero("reset_async");
        model_reset();
        tx_bits.delete();
        for (int i = 0; i < slip; i++) tx_bits.push_back(rnd ? 1'($urandom) : 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // A symbol is seen one window after its word, so lock lands on the 9th token.
    task automatic lock_run(input string name, input logic [9:0] a, input logic [9:0] b,
                            input int exp_off);
        for (int i = 0; i < 8; i++) send((i % 2) ? b : a);
        check({name, "_not_locked_early"}, 32'(rx_if.locked), 32'd0);
        send(b);
        check({name, "_locked"}, 32'(rx_if.locked), 32'd1);
        check({name, "_offset"}, 32'(rx_if.bit_offset), 32'(exp_off));
        for (int i = 0; i < 7; i++) send((i % 2) ? b : a);
        check({name, "_is_ctrl"}, 32'(rx_if.is_ctrl), 32'd1);
        check({name, "_valid"}, 32'(rx_if.data_valid), 32'd1);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("scoreboard", 32'({rx_if.data_out, rx_if.data_valid, rx_if.is_ctrl, rx_if.locked,
                                     rx_if.bit_offset, rx_if.realign_count}), 32'(e));
        end
    end

    initial begin
        rx_if.raw_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_initial");
        #1 rst_n = 1'b1;

        lock_run("aligned", TOK_354, TOK_354, 0);
        for (int i = 0; i < 12; i++) send(10'($urandom));

        do_reset(3, 1'b0);
        lock_run("slip3", TOK_354, TOK_354, 3);
        for (int i = 0; i < 8; i++) send(10'($urandom));

        do_reset(7, 1'b0);
        lock_run("alt7", TOK_154, TOK_2AB, 7);

        do_reset(0, 1'b0);
        for (int i = 0; i < 5; i++) send(TOK_354);
        for (int i = 0; i < 3; i++) send(PIX_1F0);
        check("partial_not_locked", 32'(rx_if.locked), 32'd0);
        check("partial_back_to_search", 32'(rx_if.data_valid), 32'd0);
        lock_run("relock", TOK_354, TOK_354, 0);

        // Offset 0: the first pixel word still shows the last token in the window.
        do_reset(0, 1'b0);
        for (int it = 0; it < 300; it++) begin
            for (int i = 0; i < 12; i++) send(TOK_354);
            check("timeout_locked", 32'(rx_if.locked), 32'd1);
            for (int i = 0; i < 16; i++) send(PIX_1F0);
            check("timeout_hold_15", 32'(rx_if.locked), 32'd1);
            send(PIX_1F0);
            check("timeout_drop_16", 32'(rx_if.locked), 32'd0);
            for (int i = 0; i < 3; i++) send(PIX_1F0);
            check("realign_count", 32'(rx_if.realign_count), 32'((it + 1 > 255) ? 255 : it + 1));
        end

        for (int i = 0; i < 12; i++) send(TOK_354);
        check("locked_before_reset", 32'(rx_if.locked), 32'd1);
        do_reset(0, 1'b0);
        lock_run("after_locked_reset", TOK_354, TOK_354, 0);

        do_reset(0, 1'b0);
        for (int i = 0; i < 5; i++) send(TOK_354);
        check("mid_verify_valid", 32'(rx_if.data_valid), 32'd1);
        check("mid_verify_unlocked", 32'(rx_if.locked), 32'd0);
        do_reset(0, 1'b0);
        lock_run("after_verify_reset", TOK_354, TOK_354, 0);

        do_reset(int'($urandom_range(0, 9)), 1'b1);
        for (int seg = 0; seg < 8; seg++) begin
            int npix;
            int ntok;
            npix = int'($urandom_range(5, 40));
            ntok = int'($urandom_range(3, 20));
            for (int i = 0; i < npix; i++) send(10'($urandom));
            for (int i = 0; i < ntok; i++) send(toks[$urandom_range(0, 3)]);
        end

        #20;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
